spike_weight_fetch: RTL and testbench
=====================================

// Module: spike_weight_fetch
// PURPOSE
//  Upstream feeder for the per-neuron floating-point accumulating MAC.
//  - Buffers incoming spike source addresses in a small FIFO.
//  - Looks each one up in a local synapse table of (source address, weight) pairs.
//  - Streams the matching IEEE-754 single-precision weight to the accumulator's weight input.
//  - Drives weight_out to +0.0 on every cycle with no weight to deliver, because the
//    accumulator adds its input on every clock.
// PARAMETERS
//  N_SYN       5    number of synapse table entries
//  ADDR_W      12   spike source address width
//  FIFO_DEPTH  4    spike FIFO depth in entries; power of 2
//  IDX_W       $clog2(N_SYN)   derived table index width; not overridden
// PORTS
//  clk          in   1       clock; all state changes on the rising edge
//  reset        in   1       asynchronous, active-high reset
//  set          in   1       config write strobe; writes table[cfg_idx] and sets its valid bit
//  cfg_idx      in   IDX_W   table entry written on set
//  cfg_src      in   ADDR_W  source address stored on set
//  cfg_weight   in   32      fp32 weight stored on set
//  clear        in   1       end of timestep: flush FIFO, abort lookup; table kept
//  spike_valid  in   1       spike offered
//  spike_src    in   ADDR_W  source address of the offered spike
//  spike_ready  out  1       FIFO not full
//  weight_out   out  32      weight to accumulator; 32'h0000_0000 unless weight_valid
//  weight_valid out  1       weight_out carries a matched weight this cycle
//  busy         out  1       FIFO non-empty or FSM not in IDLE
// BEHAVIOUR
//  Reset values
//  - All table valid bits 0, FIFO empty, FSM in IDLE.
//  - weight_out = 0, weight_valid = 0, busy = 0, spike_ready = 1.
//  Input handshake
//  - A spike is pushed on any edge where spike_valid && spike_ready.
//  - spike_ready = !full, computed combinationally.
//  - Push when full is impossible. Simultaneous push and pop is allowed at any occupancy.
//  Table
//  - A set write takes effect at the edge; it is legal in any state.
//  - An in-flight search compares against the table contents as they are at each edge.
//  - Entries with valid = 0 never match.
//  FSM (weight_out and weight_valid registered)
//  - IDLE: if the FIFO is non-empty, pop the head into cur_src, set idx = 0, go to SEARCH.
//  - SEARCH: compare entry idx against cur_src.
//    - Match: load weight_out = table[idx].weight, weight_valid = 1, go to EMIT.
//    - No match and idx == N_SYN-1: miss; go to IDLE with no output.
//    - No match otherwise: idx++.
//  - EMIT: one cycle only. Next edge clears weight_out to 0 and weight_valid to 0, goes to IDLE.
//  Match and latency rules
//  - Only the lowest-index match is used; duplicate table entries are ignored.
//  - A spike pushed at edge E with a match at index k:
//    - weight_valid is high for exactly the cycle after edge E+2+k.
//  - A miss costs N_SYN+1 cycles of FSM time.
//  Clear
//  - clear at an edge empties the FIFO, forces IDLE, and zeroes weight_out and weight_valid.
//  - A push on the same edge as clear is dropped.
//  - clear overrides any pop or emit on that edge.
//  Reset mid-operation: async reset returns everything to the reset values immediately.
// CONFIGURATION
//  MISS_CNT_EN
//  - Defined: adds output port miss_count[15:0], reset to 0, cleared by clear.
//    - Increments on every SEARCH miss and saturates at 16'hFFFF.
//    - clear and a miss on the same edge give 0.
//  - Undefined: the port and its counter are absent; behaviour is otherwise identical.
// TESTING
//  1. Reset: check the reset values, then idle 10 cycles.
//     -> weight_out == 0 and weight_valid == 0 throughout.
//  2. Write table[0]={0x005,0x3F800000} and table[3]={0x0A1,0x40000000}; push 0x0A1 at edge E.
//     -> weight_valid is high for one cycle after E+5 with weight_out = 0x40000000.
//  3. Push 0x7FF (no entry).
//     -> No weight_valid within 10 cycles; miss_count == 1 when MISS_CNT_EN is defined.
//  4. Push 0x005 four times back-to-back with a table hit at index 0.
//     -> spike_ready drops only while full; four pulses of 0x3F800000, none lost.
//  5. Fill the FIFO with 4 spikes, assert clear mid-SEARCH.
//     -> FIFO empties, busy = 0 next cycle, no further weight_valid.
//  6. Duplicate source 0x033 at indices 1 and 4 with different weights.
//     -> Only the index-1 weight is emitted; assert reset mid-SEARCH and check outputs are 0 at once.

Source files
------------

// File: rtl/spike_weight_fetch.sv
// spike_weight_fetch: buffers spike source addresses in a small FIFO, looks
// each one up in a local synapse table (lowest matching index wins) and
// streams the matched fp32 weight to an accumulating MAC. weight_out holds
// +0.0 on every cycle without a weight, because the accumulator adds its
// input on every clock.
//
// Optional build macro MISS_CNT_EN adds a saturating 16-bit miss counter
// output (miss_count), cleared by reset and by clear.
//
// Handshake: a spike is accepted on any rising edge where spike_valid and
// spike_ready are both high; spike_ready is simply "FIFO not full", and a
// push on the same edge as clear is dropped.
module spike_weight_fetch #(
  parameter int N_SYN      = 5,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [31:0]       cfg_weight,
  input  logic              clear,
  input  logic              spike_valid,
  input  logic [ADDR_W-1:0] spike_src,
  output logic              spike_ready,
  output logic [31:0]       weight_out,
  output logic              weight_valid,
`ifdef MISS_CNT_EN
  output logic [15:0]       miss_count,
`endif
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // synapse table
  logic [N_SYN-1:0]  tbl_valid;
  logic [ADDR_W-1:0] tbl_src    [N_SYN];
  logic [31:0]       tbl_weight [N_SYN];

  // spike FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;

  // search datapath
  logic [ADDR_W-1:0] cur_src;
  logic [IDX_W-1:0]  idx;
  logic              hit;
  logic              last_idx;
  logic              miss;

  logic [31:0]       weight_next;
  logic              valid_next;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign spike_ready = !fifo_full;
  assign push        = spike_valid && !fifo_full && !clear;
  assign pop         = (state == IDLE) && !fifo_empty && !clear;

  assign hit      = (state == SEARCH) && tbl_valid[idx] && (tbl_src[idx] == cur_src);
  assign last_idx = (idx == IDX_W'(N_SYN - 1));
  assign miss     = (state == SEARCH) && !hit && last_idx && !clear;

  assign busy = !fifo_empty || (state != IDLE);

  // table writes; valid bits cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_valid <= '0;
      for (int i = 0; i < N_SYN; i++) begin
        tbl_src[i]    <= '0;
        tbl_weight[i] <= '0;
      end
    end else if (set && (32'(cfg_idx) < N_SYN)) begin
      tbl_valid[cfg_idx]  <= 1'b1;
      tbl_src[cfg_idx]    <= cfg_src;
      tbl_weight[cfg_idx] <= cfg_weight;
    end
  end

  // FIFO storage; contents need no reset, pointers define occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= spike_src;
    end
  end

  // FIFO pointers; clear flushes by re-aligning both pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // search registers: load the popped spike, then walk the table index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_src <= '0;
      idx     <= '0;
    end else if (pop) begin
      cur_src <= fifo_mem[rd_ptr[PTR_W-1:0]];
      idx     <= '0;
    end else if ((state == SEARCH) && !hit && !last_idx && !clear) begin
      idx <= idx + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; clear forces IDLE from any state
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (!fifo_empty) state_next = SEARCH;
        SEARCH:  begin
          if (hit)           state_next = EMIT;
          else if (last_idx) state_next = IDLE;
        end
        EMIT:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM output logic: a weight is loaded only on a search hit, else +0.0
  always_comb begin
    weight_next = 32'h0000_0000;
    valid_next  = 1'b0;
    if (!clear && hit) begin
      weight_next = tbl_weight[idx];
      valid_next  = 1'b1;
    end
  end

  // registered weight outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_out   <= 32'h0000_0000;
      weight_valid <= 1'b0;
    end else begin
      weight_out   <= weight_next;
      weight_valid <= valid_next;
    end
  end

`ifdef MISS_CNT_EN
  // saturating miss counter; clear wins over a same-edge miss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_count <= 16'h0000;
    end else if (clear) begin
      miss_count <= 16'h0000;
    end else if (miss && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_spike_weight_fetch.sv
// Testbench for spike_weight_fetch: directed spikes, expected weights and
// their arrival cycles pushed into a queue, a negedge monitor pops and
// compares whenever weight_valid is high.
module tb_spike_weight_fetch;

  localparam int N_SYN  = 5;
  localparam int ADDR_W = 12;
  localparam int IDX_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              set;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_src;
  logic [31:0]       cfg_weight;
  logic              clear;
  logic              spike_valid;
  logic [ADDR_W-1:0] spike_src;
  logic              spike_ready;
  logic [31:0]       weight_out;
  logic              weight_valid;
  logic              busy;
`ifdef MISS_CNT_EN
  logic [15:0]       miss_count;
`endif

  spike_weight_fetch #(.N_SYN(N_SYN), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .set(set),
    .cfg_idx(cfg_idx),
    .cfg_src(cfg_src),
    .cfg_weight(cfg_weight),
    .clear(clear),
    .spike_valid(spike_valid),
    .spike_src(spike_src),
    .spike_ready(spike_ready),
    .weight_out(weight_out),
    .weight_valid(weight_valid),
`ifdef MISS_CNT_EN
    .miss_count(miss_count),
`endif
    .busy(busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          exp_t_q[$];
  logic [31:0] mon_w;
  int          mon_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_weight(input logic [31:0] w, input int t);
    exp_q.push_back(w);
    exp_t_q.push_back(t);
  endtask

  // monitor: every delivered weight must match the head of the queue
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (weight_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_weight actual=%h required=none (cycle %0d)", weight_out, cyc);
        end else begin
          mon_w = exp_q.pop_front();
          mon_t = exp_t_q.pop_front();
          check("weight_value", weight_out, mon_w);
          check("weight_cycle", 32'(cyc), 32'(mon_t));
        end
      end else begin
        check("zero_when_idle", weight_out, 32'h0);
      end
    end
  end

  // driver tasks
  task automatic cfg_write(input logic [IDX_W-1:0] i, input logic [ADDR_W-1:0] s, input logic [31:0] w);
    set = 1'b1; cfg_idx = i; cfg_src = s; cfg_weight = w;
    @(negedge clk);
    set = 1'b0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] s);
    spike_valid = 1'b1; spike_src = s;
    @(negedge clk);
    spike_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'h0);
    repeat (3) @(negedge clk);
  endtask

  int e;

  initial begin
    reset = 1'b1; set = 1'b0; cfg_idx = '0; cfg_src = '0; cfg_weight = '0;
    clear = 1'b0; spike_valid = 1'b0; spike_src = '0;

    // 1. reset values, then idle
    repeat (2) @(negedge clk);
    check("rst_weight_out", weight_out, 32'h0);
    check("rst_weight_valid", 32'(weight_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_spike_ready", 32'(spike_ready), 32'h1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_valid", 32'(weight_valid), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
    end

    // 2. hit at index 3: valid in the cycle after E+5
    cfg_write(3'd0, 12'h005, 32'h3F80_0000);
    cfg_write(3'd3, 12'h0A1, 32'h4000_0000);
    e = cyc + 1;
    expect_weight(32'h4000_0000, e + 5);
    push(12'h0A1);
    wait_drain();

    // 3. miss: no weight within 10 cycles
    push(12'h7FF);
    repeat (10) @(negedge clk);
    check("miss_busy", 32'(busy), 32'h0);
`ifdef MISS_CNT_EN
    check("miss_count_1", 32'(miss_count), 32'h1);
`endif

    // 4. four back-to-back hits at index 0: one every three cycles
    e = cyc + 1;
    expect_weight(32'h3F80_0000, e + 2);
    expect_weight(32'h3F80_0000, e + 5);
    expect_weight(32'h3F80_0000, e + 8);
    expect_weight(32'h3F80_0000, e + 11);
    for (int i = 0; i < 4; i++) begin
      check("b2b_ready", 32'(spike_ready), 32'h1);
      push(12'h005);
    end
    wait_drain();

    // 5. fill the FIFO (one spike already popped), clear mid-search
    for (int i = 0; i < 5; i++) begin
      check("fill_ready", 32'(spike_ready), 32'h1);
      push(12'h100 + 12'(i));
    end
    check("full_ready", 32'(spike_ready), 32'h0);
    check("full_busy", 32'(busy), 32'h1);
    pulse_clear();
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_ready", 32'(spike_ready), 32'h1);
    check("clr_valid", 32'(weight_valid), 32'h0);
    repeat (10) @(negedge clk);
    check("clr_busy_later", 32'(busy), 32'h0);
`ifdef MISS_CNT_EN
    check("miss_count_clr", 32'(miss_count), 32'h0);
`endif

    // 6. duplicate source: lowest index wins; then async reset mid-search
    cfg_write(3'd1, 12'h033, 32'h4040_0000);
    cfg_write(3'd4, 12'h033, 32'h4080_0000);
    e = cyc + 1;
    expect_weight(32'h4040_0000, e + 3);
    push(12'h033);
    push(12'h7FF);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_valid", 32'(weight_valid), 32'h0);
    check("async_rst_weight", weight_out, 32'h0);
    check("async_rst_ready", 32'(spike_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // table valid bits were reset: a former hit now misses
    push(12'h005);
    repeat (10) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
